rtc_mtimer: RTL and testbench
=============================

Name: rtc_mtimer

Overview:
- Memory-mapped RISC-V machine timer (CLINT-style mtime/mtimecmp) for the PUC-RS5 SoC.
- Holds a free-running 64-bit mtime counter and a 64-bit mtimecmp compare register.
- Raises the machine timer interrupt (MTIP, IRQ bit 7) when mtime >= mtimecmp.
- Exports mtime directly to the core for the time/timeh CSRs.
- Accessed through the core's data bus; the bus decoder asserts en_i for addresses 0x2000_0000–0x7FFF_FFFF.

Parameters:
- TICK_DIV, 1: clock cycles per mtime increment; legal range 1..65535; 1 means increment every cycle.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- en_i  input  1  bus access strobe for this block; one-cycle pulse per access.
- addr_i  input  4  byte offset within block. Bit 3: 0 = mtime, 1 = mtimecmp. Bit 2: 0 = low word, 1 = high word. Bits 1:0 ignored.
- we_i  input  8  byte write enables; all zero means read.
- data_i  input  64  write data.
- data_o  output  64  registered read data.
- mti_o  output  1  machine timer interrupt pending.
- mtime_o  output  64  current mtime value.

Behaviour:
- Reset (reset low, asynchronous): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler count=0, data_o=0. Consequently mti_o=0 while reset is held.
- Prescaler: internal counter 0..TICK_DIV-1. When it reaches TICK_DIV-1 it wraps to 0 and mtime increments by 1. mtime wraps from 2^64-1 to 0 with no flag.
- Write cycle (en_i=1 and we_i≠0), applied at the clock edge:
  - Target register selected by addr_i[3].
  - addr_i[2]=0: byte k of the target is written from data_i[8k+7:8k] where we_i[k]=1, k=0..7.
  - addr_i[2]=1 (32-bit high-word access): bytes 4..7 of the target are written from data_i[31:0], using we_i[3:0] as the lane enables; we_i[7:4] and data_i[63:32] are ignored.
  - Unwritten bytes keep their value.
- Write to mtime in a given cycle: the written bytes take the written value and the increment for that cycle is suppressed; bytes not written keep the pre-increment value. The prescaler is not reset.
- Write to mtimecmp: mtime continues counting normally.
- Read cycle (en_i=1 and we_i=0):
  - data_o is loaded at the edge with the selected register's pre-edge value, giving 1-cycle latency.
  - addr_i[2]=0: data_o = full 64-bit register.
  - addr_i[2]=1: data_o = {32'h0, register[63:32]}, so a 32-bit master sees the high word on data_o[31:0].
- Write cycles also load data_o with the pre-write value of the addressed register/word, using the same formatting as a read.
- en_i=0: data_o holds its value; no register changes except mtime counting.
- mti_o is combinational: (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
  - Level-sensitive; deasserts only when software raises mtimecmp above mtime or writes mtime below mtimecmp.
  - No acknowledge input.
- mtime_o = mtime register, combinational from the register with no extra delay.
- Unused address combinations (bits 1:0 ≠ 0) are treated by bits 3:2 only; no error response.

Test Plan:
1. Reset then release, TICK_DIV=1:
   - mtime_o reads 0, 1, 2, … on successive edges.
   - mti_o=0.
   - Read addr 0x8 returns data_o=32'hFFFF_FFFF on the next cycle; addr 0xC also returns 32'hFFFF_FFFF.
2. Write mtimecmp low word: addr 0x8, we_i=8'h0F, data_i=32'd20; then write addr 0xC, we_i=8'h0F, data_i=0:
   - mti_o rises on the cycle mtime_o reaches 20 and stays high.
3. After test 2, write addr 0x8 with data 1000:
   - mti_o drops the cycle after the write edge.
   - Then write mtime (addr 0x0) with data 2000: mti_o reasserts immediately after that edge and mtime_o=2000, not 2001.
4. Byte lanes: write mtime addr 0x0, we_i=8'h02, data_i=32'h0000_AB00 while mtime=0x10:
   - mtime becomes 0x0000_AB10 (byte 1 replaced, increment suppressed), then counts on.
5. High word and wrap: write addr 0x4 data 32'hFFFF_FFFF, then addr 0x0 data 32'hFFFF_FFFE:
   - mtime_o reaches 64'hFFFF_FFFF_FFFF_FFFF, then 0.
   - Read addr 0x4 returns the high word on data_o[31:0] one cycle later.
6. Asynchronous reset mid-count (TICK_DIV=4, mtime=57, mtimecmp=10, mti_o=1): pull reset low between edges:
   - mtime_o=0, mti_o=0, data_o=0 immediately without waiting for a clock edge.
   - After release, mtime increments every 4 cycles.

Source files
------------

// File: rtl/rtc_mtimer.sv
// RISC-V machine timer: free-running 64-bit mtime with prescaler, mtimecmp compare
// register, byte-lane bus access and a level-sensitive timer interrupt.
`timescale 1ns/1ps
module rtc_mtimer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  addr_i,
    input  logic [7:0]  we_i,
    input  logic [63:0] data_i,
    output logic [63:0] data_o,
    output logic        mti_o,
    output logic [63:0] mtime_o
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] presc;
    logic        tick;

    logic        wr_cycle;
    logic        wr_mtime;
    logic        wr_cmp;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;
    logic [63:0] mtime_wr;
    logic [63:0] cmp_wr;
    logic [63:0] rd_sel;
    logic [63:0] rd_fmt;

    // Low address bits only select within a word and carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^addr_i[1:0];

    assign tick     = (presc == 16'(TICK_DIV - 1));
    assign wr_cycle = en_i & (|we_i);
    assign wr_mtime = wr_cycle & ~addr_i[3];
    assign wr_cmp   = wr_cycle &  addr_i[3];

    // A high-word access is a 32-bit master: its lanes/data sit in the low half.
    always_comb begin
        wr_be   = we_i;
        wr_data = data_i;
        if (addr_i[2]) begin
            wr_be   = {we_i[3:0], 4'b0000};
            wr_data = {data_i[31:0], 32'h0};
        end
    end

    always_comb begin
        mtime_wr = mtime;
        cmp_wr   = mtimecmp;
        for (int k = 0; k < 8; k++) begin
            if (wr_be[k]) begin
                mtime_wr[8*k +: 8] = wr_data[8*k +: 8];
                cmp_wr[8*k +: 8]   = wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_sel = addr_i[3] ? mtimecmp : mtime;
        rd_fmt = addr_i[2] ? {32'h0, rd_sel[63:32]} : rd_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime    <= 64'h0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc    <= 16'h0;
            data_o   <= 64'h0;
        end else begin
            presc <= tick ? 16'h0 : presc + 16'h1;
            // A software write to mtime wins over the tick for that cycle.
            if (wr_mtime)
                mtime <= mtime_wr;
            else if (tick)
                mtime <= mtime + 64'h1;
            if (wr_cmp)
                mtimecmp <= cmp_wr;
            if (en_i)
                data_o <= rd_fmt;
        end
    end

    assign mti_o   = (mtime >= mtimecmp);
    assign mtime_o = mtime;

endmodule

// File: tb/tb_rtc_mtimer.sv
// Directed bench for rtc_mtimer: one TICK_DIV=1 instance for the bus/compare
// scenarios and one TICK_DIV=4 instance for the asynchronous reset scenario.
`timescale 1ns/1ps
module tb_rtc_mtimer;

    logic        clk;
    logic        rst_n;
    logic        rst4_n;
    logic        en;
    logic [3:0]  addr;
    logic [7:0]  we;
    logic [63:0] din;
    logic [63:0] dout;
    logic        mti;
    logic [63:0] mtime;
    logic [63:0] dout4;
    logic        mti4;
    logic [63:0] mtime4;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_mtimer #(.TICK_DIV(1)) dut (
        .clk(clk), .reset(rst_n), .en_i(en), .addr_i(addr), .we_i(we),
        .data_i(din), .data_o(dout), .mti_o(mti), .mtime_o(mtime)
    );

    rtc_mtimer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(rst4_n), .en_i(en), .addr_i(addr), .we_i(we),
        .data_i(din), .data_o(dout4), .mti_o(mti4), .mtime_o(mtime4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus access: applied at the next rising edge, returns 1ns after it.
    task automatic bus(input logic [3:0] a, input logic [7:0] w, input logic [63:0] d);
        en = 1'b1; addr = a; we = w; din = d;
        @(posedge clk); #1;
        en = 1'b0; we = 8'h0; din = 64'h0; addr = 4'h0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (mtime !== 64'h0) begin n_fail++; $display("FAIL reset_mtime got %h want 0", mtime); end
        n_checks++;
        if (mti !== 1'b0) begin n_fail++; $display("FAIL reset_mti got %b want 0", mti); end
        n_checks++;
        if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", dout); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (mtime !== 64'h0) begin n_fail++; $display("FAIL release_mtime got %h want 0", mtime); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mtime !== 64'(k)) begin n_fail++; $display("FAIL count_mtime got %h want %h", mtime, 64'(k)); end
            n_checks++;
            if (mti !== 1'b0) begin n_fail++; $display("FAIL count_mti got %b want 0", mti); end
        end
    endtask

    task automatic test_read_cmp;
        bus(4'h8, 8'h00, 64'h0);
        n_checks++;
        if (dout !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL rd_cmp_lo got %h want all ones", dout); end
        bus(4'hC, 8'h00, 64'h0);
        n_checks++;
        if (dout !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL rd_cmp_hi got %h want 00000000ffffffff", dout); end
    endtask

    task automatic test_cmp_irq;
        bus(4'h0, 8'hFF, 64'h0);                    // mtime := 0
        n_checks++;
        if (mtime !== 64'h0) begin n_fail++; $display("FAIL wr_mtime0 got %h want 0", mtime); end
        bus(4'h8, 8'h0F, 64'd20);                   // mtime 1
        bus(4'hC, 8'h0F, 64'd0);                    // mtime 2, cmp = 20
        n_checks++;
        if (mtime !== 64'd2 || mti !== 1'b0) begin
            n_fail++; $display("FAIL cmp_setup got mtime=%0d mti=%b want 2/0", mtime, mti);
        end
        for (int k = 3; k <= 25; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mtime !== 64'(k) || mti !== (k >= 20)) begin
                n_fail++; $display("FAIL irq_rise got mtime=%0d mti=%b want %0d/%b", mtime, mti, k, (k >= 20));
            end
        end
    endtask

    task automatic test_cmp_raise;
        bus(4'h8, 8'h0F, 64'd1000);                 // cmp = 1000, mtime 26
        n_checks++;
        if (mti !== 1'b0) begin n_fail++; $display("FAIL irq_drop got %b want 0", mti); end
        n_checks++;
        if (dout !== 64'd20) begin n_fail++; $display("FAIL wr_prev_cmp got %0d want 20", dout); end
        bus(4'h0, 8'h0F, 64'd2000);
        n_checks++;
        if (mtime !== 64'd2000 || mti !== 1'b1) begin
            n_fail++; $display("FAIL wr_mtime_sup got mtime=%0d mti=%b want 2000/1", mtime, mti);
        end
        n_checks++;
        if (dout !== 64'd26) begin n_fail++; $display("FAIL wr_prev_mtime got %0d want 26", dout); end
        @(posedge clk); #1;
        n_checks++;
        if (mtime !== 64'd2001) begin n_fail++; $display("FAIL post_wr_count got %0d want 2001", mtime); end
    endtask

    task automatic test_byte_lanes;
        bus(4'h0, 8'hFF, 64'h10);
        bus(4'h0, 8'h02, 64'h0000_AB00);
        n_checks++;
        if (mtime !== 64'h0000_AB10) begin n_fail++; $display("FAIL byte_lane got %h want ab10", mtime); end
        @(posedge clk); #1;
        n_checks++;
        if (mtime !== 64'h0000_AB11) begin n_fail++; $display("FAIL byte_lane_count got %h want ab11", mtime); end
    endtask

    task automatic test_wrap;
        bus(4'h4, 8'hFF, 64'hDEAD_BEEF_FFFF_FFFF);  // upper lanes/data must be ignored
        n_checks++;
        if (mtime !== 64'hFFFF_FFFF_0000_AB11) begin n_fail++; $display("FAIL hi_write got %h want ffffffff0000ab11", mtime); end
        bus(4'h0, 8'h0F, 64'hFFFF_FFFE);
        n_checks++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL lo_write got %h want fffffffffffffffe", mtime); end
        bus(4'h4, 8'h00, 64'h0);
        n_checks++;
        if (dout !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL rd_hi got %h want 00000000ffffffff", dout); end
        n_checks++;
        if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF || mti !== 1'b1) begin
            n_fail++; $display("FAIL at_max got %h mti=%b want all ones/1", mtime, mti);
        end
        @(posedge clk); #1;
        n_checks++;
        if (mtime !== 64'h0 || mti !== 1'b0) begin
            n_fail++; $display("FAIL wrap got %h mti=%b want 0/0", mtime, mti);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk); rst4_n = 1'b1;
        bus(4'h0, 8'hFF, 64'd57);
        bus(4'h8, 8'hFF, 64'd10);
        bus(4'h8, 8'h00, 64'h0);
        n_checks++;
        if (mti4 !== 1'b1 || dout4 !== 64'd10) begin
            n_fail++; $display("FAIL div4_setup got mti=%b data=%0d want 1/10", mti4, dout4);
        end
        #2 rst4_n = 1'b0; #1;
        n_checks++;
        if (mtime4 !== 64'h0 || mti4 !== 1'b0 || dout4 !== 64'h0) begin
            n_fail++; $display("FAIL async_rst got mtime=%0d mti=%b data=%0d want 0/0/0", mtime4, mti4, dout4);
        end
        @(negedge clk); rst4_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mtime4 !== 64'(k / 4)) begin
                n_fail++; $display("FAIL div4_count edge %0d got %0d want %0d", k, mtime4, k / 4);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; rst4_n = 1'b0;
        en = 1'b0; addr = 4'h0; we = 8'h0; din = 64'h0;
        test_reset;
        test_read_cmp;
        test_cmp_irq;
        test_cmp_raise;
        test_byte_lanes;
        test_wrap;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
